// File: rtl/exp_result_buffer_if.sv
// Handshake and status bundle between the exp(x) pipeline, the result buffer and its consumer.
// The slave side is the buffer; the master side is the pipeline/consumer pair.
interface exp_result_buffer_if #(
  parameter int DEPTH    = 8,
  parameter int WIDTHIN  = 32,
  parameter int WIDTHOUT = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                i_valid;
  logic                o_ready;
  logic [WIDTHIN-1:0]  i_y;
  logic                o_valid;
  logic                i_ready;
  logic [WIDTHOUT-1:0] o_y;
  logic [CW-1:0]       o_count;
  logic [15:0]         o_sat_count;

  modport slave (
    input  i_valid, i_y, i_ready,
    output o_ready, o_valid, o_y, o_count, o_sat_count
  );

  modport master (
    output i_valid, i_y, i_ready,
    input  o_ready, o_valid, o_y, o_count, o_sat_count
  );
endinterface

// File: rtl/exp_result_buffer.sv
// Rounds Q7.25 results to saturated Q6.10 into a FWFT FIFO; an empty-FIFO push is visible one cycle later.
// o_ready drops only when full and never looks at i_ready; the saturation counter sticks at 0xFFFF.
module exp_result_buffer #(
  parameter int DEPTH    = 8,
  parameter int WIDTHIN  = 32,
  parameter int WIDTHOUT = 16
) (
  input logic                  clk,
  input logic                  reset,
  exp_result_buffer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [15:0]         sat_count_q, sat_count_d;
  logic [WIDTHOUT-1:0] mem_q [DEPTH];

  logic                ready;
  logic                valid;
  logic                push;
  logic                pop;
  logic [WIDTHOUT:0]   rnd;
  logic                sat;
  logic [WIDTHOUT-1:0] conv;

  assign ready           = (count_q != CW'(DEPTH));
  assign valid           = (count_q != '0);
  assign push            = bus.i_valid & ready;
  assign pop             = valid & bus.i_ready;

  assign bus.o_ready     = ready;
  assign bus.o_valid     = valid;
  assign bus.o_y         = mem_q[rd_ptr_q];
  assign bus.o_count     = count_q;
  assign bus.o_sat_count = sat_count_q;

  // Keep 16 bits below the sign-free integer MSB, round half up on the next bit down.
  always_comb begin
    rnd  = {1'b0, bus.i_y[WIDTHIN-2 -: WIDTHOUT]}
         + {{WIDTHOUT{1'b0}}, bus.i_y[WIDTHIN-2-WIDTHOUT]};
    sat  = bus.i_y[WIDTHIN-1] | rnd[WIDTHOUT];
    conv = sat ? '1 : rnd[WIDTHOUT-1:0];
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    sat_count_d = sat_count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push && sat && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sat_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sat_count_q <= sat_count_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= conv;
    end
  end
endmodule

// File: tb/tb_exp_result_buffer.sv
// Randomized and directed bench for exp_result_buffer against a queue-based reference model.
module tb_exp_result_buffer;
  localparam int DEPTH    = 8;
  localparam int WIDTHIN  = 32;
  localparam int WIDTHOUT = 16;

  logic clk;
  logic reset;

  exp_result_buffer_if #(.DEPTH(DEPTH), .WIDTHIN(WIDTHIN), .WIDTHOUT(WIDTHOUT)) bus ();

  exp_result_buffer #(.DEPTH(DEPTH), .WIDTHIN(WIDTHIN), .WIDTHOUT(WIDTHOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errs   = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  int          sat_m  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Q6.10 value is round(y / 2^15) with halves going up; anything >= 64.0 saturates.
  function automatic logic [15:0] ref_conv(input logic [31:0] y, output bit s);
    longint unsigned v;
    v = ({32'd0, y} + 64'd16384) / 64'd32768;
    s = (y >= 32'h8000_0000) || (v > 64'd65535);
    return s ? 16'hFFFF : v[15:0];
  endfunction

  task automatic check_outputs();
    chk("o_valid", 32'(bus.o_valid), 32'(exp_q.size() != 0));
    chk("o_ready", 32'(bus.o_ready), 32'(exp_q.size() != DEPTH));
    chk("o_count", 32'(bus.o_count), 32'(exp_q.size()));
    chk("o_sat_count", 32'(bus.o_sat_count), 32'(sat_m));
    if (exp_q.size() != 0) chk("o_y", 32'(bus.o_y), 32'(exp_q[0]));
  endtask

  task automatic cycle(input bit v, input logic [31:0] y, input bit r);
    bit          acc, pp, s;
    logic [15:0] c;
    bus.i_valid = v;
    bus.i_y     = y;
    bus.i_ready = r;
    acc = v && (exp_q.size() < DEPTH);
    pp  = r && (exp_q.size() > 0);
    c   = ref_conv(y, s);
    @(posedge clk);
    #1;
    if (pp) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(c);
      if (s && sat_m < 65535) sat_m++;
    end
    check_outputs();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    logic [31:0] y;
    bit          v, r;
    reset       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_y     = '0;
    bus.i_ready = 1'b0;
    #1;
    check_outputs();
    #3 reset = 1'b1;

    // 1.0 maps to 0x0400 on the very first edge after reset
    cycle(1'b1, 32'h0200_0000, 1'b0);
    chk("one_y", 32'(bus.o_y), 32'h0400);
    chk("one_count", 32'(bus.o_count), 32'd1);
    drain();

    cycle(1'b1, 32'h0200_3FFF, 1'b1);
    chk("round_dn", 32'(bus.o_y), 32'h0400);
    cycle(1'b1, 32'h0200_4000, 1'b1);
    chk("round_up", 32'(bus.o_y), 32'h0401);
    drain();

    cycle(1'b1, 32'h8000_0000, 1'b0);
    cycle(1'b1, 32'h7FFF_C000, 1'b0);
    chk("sat_cnt2", 32'(bus.o_sat_count), 32'd2);
    cycle(1'b1, 32'h7FFF_8000, 1'b0);
    chk("sat_exact", 32'(bus.o_sat_count), 32'd2);
    for (int k = 0; k < 3; k++) begin
      chk("sat_y", 32'(bus.o_y), 32'h0000_FFFF);
      cycle(1'b0, 32'd0, 1'b1);
    end
    drain();

    // Fill to full with the consumer stalled; the ninth word must be dropped
    for (int k = 0; k < 9; k++) begin
      cycle(1'b1, 32'h0200_0000 + 32'(k) * 32'h8000, 1'b0);
      if (k == 7) chk("full_rdy", 32'(bus.o_ready), 32'd0);
    end
    chk("full_count", 32'(bus.o_count), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk("full_order", 32'(bus.o_y), 32'h0400 + 32'(k));
      cycle(1'b0, 32'd0, 1'b1);
      if (k == 0) chk("rdy_after_pop", 32'(bus.o_ready), 32'd1);
    end
    drain();

    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 32'h0100_0000 + 32'(k) * 32'h8000, 1'b1);
      chk("wrap_count", 32'(bus.o_count), 32'd1);
    end
    drain();

    cycle(1'b1, 32'hFFFF_0000, 1'b0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'h0300_0000 + 32'(k), 1'b0);
    chk("pre_rst_count", 32'(bus.o_count), 32'd5);
    #1 reset = 1'b0;
    #1;
    exp_q.delete();
    sat_m = 0;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_count", 32'(bus.o_count), 32'd0);
    chk("rst_sat", 32'(bus.o_sat_count), 32'd0);
    #1 reset = 1'b1;
    cycle(1'b1, 32'h0200_0000, 1'b0);
    chk("post_rst_y", 32'(bus.o_y), 32'h0400);
    cycle(1'b0, 32'd0, 1'b1);
    chk("post_rst_alone", 32'(bus.o_valid), 32'd0);

    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       y = $urandom;
        1:       y = $urandom & 32'h7FFF_FFFF;
        2:       y = 32'h7FFF_8000 + ($urandom & 32'h0000_7FFF);
        default: y = ($urandom & 32'h07FF_FFFF);
      endcase
      cycle(v, y, r);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/exp_result_buffer.md
# exp_result_buffer

Downstream stage of the Taylor-series exp(x) pipeline. It accepts the pipeline's Q7.25 results over a valid/ready handshake and rounds each one to Q6.10 with saturation. Results are held in a small first-word-fall-through FIFO so that a slow consumer stalls the pipeline through backpressure instead of losing results. The block also counts saturation events for debug readback.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- WIDTHIN, 32, input width; Q7.25 unsigned.
- WIDTHOUT, 16, output width; Q6.10 unsigned.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0); clears all state immediately.
- i_valid  in  1  upstream result valid.
- o_ready  out  1  buffer can accept; feeds the pipeline's i_ready.
- i_y  in  WIDTHIN  upstream result, Q7.25.
- o_valid  out  1  head entry valid.
- i_ready  in  1  consumer ready.
- o_y  out  WIDTHOUT  head entry, Q6.10.
- o_count  out  $clog2(DEPTH)+1  current occupancy.
- o_sat_count  out  16  saturation events since reset; sticks at 0xFFFF.

## Operation
- Push: i_valid & o_ready at a rising edge writes the converted word at wr_ptr, then wr_ptr increments and wraps mod DEPTH.
- Pop: o_valid & i_ready at a rising edge advances rd_ptr, which wraps mod DEPTH.
- o_ready = (count != DEPTH). It is combinational from the registered count and never depends on i_ready.
- o_valid = (count != 0). o_y = mem[rd_ptr] is driven from storage with no extra register.
- Simultaneous push and pop while not full and not empty: both happen and count is unchanged.
- Push while empty: o_valid rises on the next cycle. Same-cycle bypass is not allowed.
- Full: o_ready = 0, so no push occurs that cycle even if a pop happens in the same cycle. o_ready rises the cycle after the pop.
- i_valid while o_ready = 0: ignored. No state changes.
- Conversion, performed on the push path before storage:
  - r = i_y[30:15] + i_y[14], a 17-bit sum (round half up).
  - If i_y[31] = 1 or r[16] = 1: store 0xFFFF and increment sat_count.
  - Otherwise store r[15:0].
- sat_count updates only on accepted pushes. It saturates at 0xFFFF and does not wrap.
- Reset asserted at any point, including mid-stream: pointers, count, and sat_count clear. In-flight entries are discarded. Memory contents need not be cleared.

## Timing
- Reset values: o_valid = 0, o_ready = 1, o_count = 0, o_sat_count = 0. o_y is don't-care while o_valid = 0.
- Latency: an input accepted at edge N is visible on o_y with o_valid = 1 after edge N, provided the FIFO was empty.
- Sustained throughput is one word per cycle when i_ready stays 1.
- After reset deasserts, the first push may occur at the first rising edge.
- Data stay stable on o_y while o_valid = 1 and i_ready = 0.

## Test plan
- Reset, then push i_y = 0x0200_0000 (1.0) -> next cycle o_valid = 1, o_y = 0x0400, o_count = 1.
- Rounding: push 0x0200_3FFF and then 0x0200_4000 with i_ready = 1 -> outputs 0x0400 then 0x0401, in order.
- Saturation: push 0x8000_0000 and then 0x7FFF_C000 -> both outputs 0xFFFF, o_sat_count = 2. Then push 0x7FFF_8000 -> output 0xFFFF (exact, not a saturation), o_sat_count stays 2.
- Full/backpressure: with i_ready = 0, push 9 words 0x0200_0000 + k·0x8000 on consecutive cycles -> o_ready = 0 after the 8th push, the 9th is not accepted, o_count = 8. Then raise i_ready -> outputs 0x0400 through 0x0407 in order, and o_ready rises one cycle after the first pop.
- Wrap and concurrency: hold i_valid = i_ready = 1 for 20 cycles with incrementing data -> o_count stays 1 after the first cycle and every word emerges in order across the pointer wrap.
- Reset mid-operation: with 5 entries stored, pulse reset low between edges -> o_valid = 0, o_count = 0, o_sat_count = 0 immediately with no clock edge, and the next push emerges alone.
